// File: rtl/starfield_pkg.sv
// Purpose: shared constants and FSM encoding for the starfield speed-ramp writer.
// Contents: register addresses, control bit indices, speed width, state enum.
package starfield_pkg;

   localparam int unsigned SPEED_W = 8;

   // CPU register map
   localparam logic [1:0] SFR_TARGET = 2'd0;
   localparam logic [1:0] SFR_STEP   = 2'd1;
   localparam logic [1:0] SFR_DIV    = 2'd2;
   localparam logic [1:0] SFR_CTRL   = 2'd3;

   // Control register bits
   localparam int unsigned SFR_CTRL_JUMP = 0;
   localparam int unsigned SFR_CTRL_HOLD = 1;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_STEP  = 3'd3,
      ST_WRITE = 3'd4
   } sf_state_e;

endpackage

// File: rtl/speed_step.sv
// Purpose: one saturating step of the speed value toward the target.
// Ports: cur    - current speed
//        target - requested speed
//        step   - step size (0 = jump straight to target)
//        next   - new speed, never past target and never wrapped
module speed_step
   import starfield_pkg::*;
(
   input  logic [SPEED_W-1:0] cur,
   input  logic [SPEED_W-1:0] target,
   input  logic [SPEED_W-1:0] step,
   output logic [SPEED_W-1:0] next
);

   logic [SPEED_W:0] w_sum;
   logic [SPEED_W:0] w_diff;

   // Extra bit holds the carry/borrow so overshoot clamps to target.
   always_comb begin
      w_sum  = {1'b0, cur} + {1'b0, step};
      w_diff = {1'b0, cur} - {1'b0, step};
      next   = target;
      if (step != '0) begin
         if (cur < target) begin
            if (w_sum < {1'b0, target}) next = w_sum[SPEED_W-1:0];
         end else if (cur > target) begin
            if (!w_diff[SPEED_W] && (w_diff[SPEED_W-1:0] > target)) next = w_diff[SPEED_W-1:0];
         end
      end
   end

endmodule

// File: rtl/starfield_speed_ramp.sv
// Purpose: CPU-programmed speed ramp for the starfield; moves the speed one
//          step toward target every div+1 vblank rising edges and emits a
//          single-cycle write strobe with data for each new value.
// Ports: clk, rst_n (async active-low)
//        vblank                        - vertical blank level
//        cpu_addr/cpu_data_in/cpu_write - register write port
//        sf_data/sf_write              - write strobe + data to the starfield
//        cur_speed                     - last value written
//        busy                          - ramp or write outstanding
module starfield_speed_ramp
   import starfield_pkg::*;
#(
   parameter int unsigned DIV_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vblank,
   input  logic [1:0]         cpu_addr,
   input  logic [7:0]         cpu_data_in,
   input  logic               cpu_write,
   output logic [SPEED_W-1:0] sf_data,
   output logic               sf_write,
   output logic [SPEED_W-1:0] cur_speed,
   output logic               busy
);

   sf_state_e          r_state, w_state_n;
   logic [SPEED_W-1:0] r_target, r_step, r_cur, r_sf_data;
   logic [DIV_W-1:0]   r_div, r_cnt, w_cnt_n;
   logic               r_hold, r_pend, w_pend_n;
   logic               r_vblank_q, r_sf_write, r_busy, w_busy_n;
   logic               r_step_jump, w_step_jump;
   logic               w_enter_step, w_load;
   logic [SPEED_W-1:0] w_load_val, w_next;
   logic               w_vb_edge, w_jump_req;

   assign w_vb_edge  = vblank & ~r_vblank_q;
   assign w_jump_req = cpu_write && (cpu_addr == SFR_CTRL) && cpu_data_in[SFR_CTRL_JUMP];

   speed_step u_step (
      .cur    (r_cur),
      .target (r_target),
      .step   (r_step),
      .next   (w_next)
   );

   // CPU-visible registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target <= '0;
         r_step   <= SPEED_W'(1);
         r_div    <= '0;
         r_hold   <= 1'b0;
      end else if (cpu_write) begin
         case (cpu_addr)
            SFR_TARGET: r_target <= cpu_data_in;
            SFR_STEP:   r_step   <= cpu_data_in;
            SFR_DIV:    r_div    <= DIV_W'(cpu_data_in);
            default:    r_hold   <= cpu_data_in[SFR_CTRL_HOLD];
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_state_n;
   end

   // Next-state, counter, jump-pending and write-load decode
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_enter_step = 1'b0;
      w_step_jump  = 1'b0;
      w_load       = 1'b0;
      w_load_val   = r_cur;
      case (r_state)
         ST_INIT: begin
            w_load     = 1'b1;
            w_load_val = '0;
            w_state_n  = ST_WRITE;
         end
         ST_IDLE, ST_WAIT: begin
            if (r_pend) begin
               w_state_n    = ST_STEP;
               w_enter_step = 1'b1;
               w_step_jump  = 1'b1;
               w_cnt_n      = r_div;
            end else if (r_state == ST_IDLE) begin
               if (r_target != r_cur) w_state_n = ST_WAIT;
            end else if (w_vb_edge && !r_hold) begin
               if (r_cnt == '0) begin
                  w_cnt_n      = r_div;
                  w_state_n    = ST_STEP;
                  w_enter_step = 1'b1;
                  // A jump landing on the same edge replaces this step.
                  w_step_jump  = w_jump_req;
               end else begin
                  w_cnt_n = r_cnt - DIV_W'(1);
               end
            end
         end
         ST_STEP: begin
            w_load     = 1'b1;
            w_load_val = r_step_jump ? r_target : w_next;
            w_state_n  = ST_WRITE;
         end
         ST_WRITE: begin
            w_state_n = (r_cur == r_target) ? ST_IDLE : ST_WAIT;
         end
         default: w_state_n = ST_INIT;
      endcase

      if (w_enter_step)    w_pend_n = 1'b0;
      else if (w_jump_req) w_pend_n = 1'b1;
      else                 w_pend_n = r_pend;

      w_busy_n = (w_state_n != ST_IDLE) | w_pend_n;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vblank_q  <= 1'b0;
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_step_jump <= 1'b0;
         r_sf_write  <= 1'b0;
         r_sf_data   <= '0;
         r_cur       <= '0;
         r_busy      <= 1'b1;
      end else begin
         r_vblank_q <= vblank;
         r_cnt      <= w_cnt_n;
         r_pend     <= w_pend_n;
         r_sf_write <= w_load;
         r_busy     <= w_busy_n;
         if (w_enter_step) r_step_jump <= w_step_jump;
         if (w_load) begin
            r_sf_data <= w_load_val;
            r_cur     <= w_load_val;
         end
      end
   end

   assign sf_data   = r_sf_data;
   assign sf_write  = r_sf_write;
   assign cur_speed = r_cur;
   assign busy      = r_busy;

endmodule

// File: tb/tb_starfield_speed_ramp.sv
module tb_starfield_speed_ramp;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vblank;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_data_in;
   logic       cpu_write;
   logic [7:0] sf_data;
   logic       sf_write;
   logic [7:0] cur_speed;
   logic       busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   starfield_speed_ramp #(.DIV_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vblank      (vblank),
      .cpu_addr    (cpu_addr),
      .cpu_data_in (cpu_data_in),
      .cpu_write   (cpu_write),
      .sf_data     (sf_data),
      .sf_write    (sf_write),
      .cur_speed   (cur_speed),
      .busy        (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every strobe must match the next queued value.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && sf_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", int'(sf_data), -1);
         end else begin
            check("sf_data", int'(sf_data), int'(exp_q.pop_front()));
            check("cur_speed_at_write", int'(cur_speed), int'(sf_data));
         end
      end
   end

   task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_addr = a; cpu_data_in = d; cpu_write = 1'b1;
      @(negedge clk);
      cpu_write = 1'b0;
   endtask

   task automatic frame();
      @(negedge clk);
      vblank = 1'b1;
      repeat (2) @(negedge clk);
      vblank = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   localparam logic [1:0] A_TGT = 2'd0, A_STEP = 2'd1, A_DIV = 2'd2, A_CTRL = 2'd3;

   initial begin
      rst_n = 1'b0; vblank = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_write = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sf_data", int'(sf_data), 0);
      check("rst_sf_write", int'(sf_write), 0);
      check("rst_cur_speed", int'(cur_speed), 0);
      check("rst_busy", int'(busy), 1);

      // Reset release: INIT write of 0 in the second cycle
      exp_q.push_back(8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("init_strobe", int'(sf_write), 1);
      repeat (3) @(negedge clk);
      check("init_busy_low", int'(busy), 0);
      check("init_cur", int'(cur_speed), 0);

      // Ramp up 0 -> 40 by 16, div 0; check strobe timing on the first step
      cpu_wr(A_STEP, 8'd16);
      cpu_wr(A_DIV, 8'd0);
      exp_q.push_back(8'd16); exp_q.push_back(8'd32); exp_q.push_back(8'd40);
      cpu_wr(A_TGT, 8'd40);
      repeat (2) @(negedge clk);
      vblank = 1'b1;
      @(negedge clk);
      check("step_no_strobe_E", int'(sf_write), 0);
      @(negedge clk);
      check("step_strobe_E1", int'(sf_write), 1);
      vblank = 1'b0;
      repeat (5) @(negedge clk);
      frames(4);
      check("up_cur", int'(cur_speed), 40);
      check("up_busy", int'(busy), 0);

      // Ramp down 40 -> 5 by 8 with div 2
      cpu_wr(A_STEP, 8'd8);
      cpu_wr(A_DIV, 8'd2);
      exp_q.push_back(8'd32); exp_q.push_back(8'd24); exp_q.push_back(8'd16);
      exp_q.push_back(8'd8);  exp_q.push_back(8'd5);
      cpu_wr(A_TGT, 8'd5);
      frames(10);
      check("down_midway_busy", int'(busy), 1);
      frames(5);
      check("down_cur", int'(cur_speed), 5);
      check("down_busy", int'(busy), 0);

      // Jump to 250, checking C+2 latency
      cpu_wr(A_DIV, 8'd0);
      cpu_wr(A_TGT, 8'd250);
      exp_q.push_back(8'd250);
      @(negedge clk);
      cpu_addr = A_CTRL; cpu_data_in = 8'h01; cpu_write = 1'b1;
      @(negedge clk);
      cpu_write = 1'b0;
      @(negedge clk);
      check("jump_no_strobe_C1", int'(sf_write), 0);
      @(negedge clk);
      check("jump_strobe_C2", int'(sf_write), 1);
      repeat (3) @(negedge clk);

      // Saturation up: 250 + 200 clamps to 255
      cpu_wr(A_STEP, 8'd200);
      exp_q.push_back(8'd255);
      cpu_wr(A_TGT, 8'd255);
      frames(3);
      check("sat_up_cur", int'(cur_speed), 255);

      // Saturation down: 3 - 200 clamps to 0
      exp_q.push_back(8'd3);
      cpu_wr(A_TGT, 8'd3);
      cpu_wr(A_CTRL, 8'h01);
      repeat (4) @(negedge clk);
      exp_q.push_back(8'd0);
      cpu_wr(A_TGT, 8'd0);
      frames(3);
      check("sat_down_cur", int'(cur_speed), 0);

      // Jump mid-ramp
      cpu_wr(A_STEP, 8'd1);
      exp_q.push_back(8'd1); exp_q.push_back(8'd2);
      cpu_wr(A_TGT, 8'd100);
      frames(2);
      exp_q.push_back(8'd200);
      cpu_wr(A_TGT, 8'd200);
      cpu_wr(A_CTRL, 8'h01);
      repeat (4) @(negedge clk);
      check("jump_mid_cur", int'(cur_speed), 200);

      // Jump and vblank edge on the same clock: a single write of the target
      cpu_wr(A_TGT, 8'd50);
      exp_q.push_back(8'd50);
      @(negedge clk);
      vblank = 1'b1;
      cpu_addr = A_CTRL; cpu_data_in = 8'h01; cpu_write = 1'b1;
      @(negedge clk);
      cpu_write = 1'b0;
      @(negedge clk);
      vblank = 1'b0;
      repeat (5) @(negedge clk);
      frames(2);
      check("jump_vb_cur", int'(cur_speed), 50);
      check("jump_vb_busy", int'(busy), 0);

      // Hold: no writes over 5 frames, busy stays high; a jump still executes
      cpu_wr(A_CTRL, 8'h02);
      cpu_wr(A_TGT, 8'd10);
      frames(5);
      check("hold_busy", int'(busy), 1);
      check("hold_cur", int'(cur_speed), 50);
      exp_q.push_back(8'd10);
      cpu_wr(A_CTRL, 8'h03);
      repeat (4) @(negedge clk);
      check("hold_jump_cur", int'(cur_speed), 10);
      cpu_wr(A_CTRL, 8'h00);

      // Reset mid-ramp
      exp_q.push_back(8'd11); exp_q.push_back(8'd12);
      cpu_wr(A_TGT, 8'd60);
      frames(2);
      check("pre_rst_cur", int'(cur_speed), 12);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_sf_data", int'(sf_data), 0);
      check("midrst_cur", int'(cur_speed), 0);
      check("midrst_busy", int'(busy), 1);
      check("midrst_sf_write", int'(sf_write), 0);
      repeat (2) @(negedge clk);
      exp_q.push_back(8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reinit_strobe", int'(sf_write), 1);
      repeat (3) @(negedge clk);
      check("reinit_cur", int'(cur_speed), 0);
      check("reinit_busy", int'(busy), 0);
      frames(2);

      check("leftover_expected", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
